// File: rtl/rans_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : rans_pkg                                                    |
// | Purpose  : Shared constants, valid_i byte-count encodings and packer   |
// |            state type for the rANS byte packer.                        |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package rans_pkg;

  localparam int WORD_BYTES = 4;

  // Byte count carried by valid_i.
  localparam logic [1:0] VLD_NONE    = 2'd0;
  localparam logic [1:0] VLD_ONE     = 2'd1;
  localparam logic [1:0] VLD_TWO     = 2'd2;
  localparam logic [1:0] VLD_ILLEGAL = 2'd3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    TAIL = 1'b1
  } pack_state_e;

  // Contiguous byte-enable mask for a word holding n bytes (n = 1..4).
  function automatic logic [WORD_BYTES-1:0] keep_mask(input logic [2:0] n);
    logic [WORD_BYTES-1:0] m;
    case (n)
      3'd1:    m = 4'b0001;
      3'd2:    m = 4'b0011;
      3'd3:    m = 4'b0111;
      3'd4:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rans_word_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : rans_word_fifo                                              |
// | Purpose  : Synchronous first-word-fall-through FIFO for packed words.  |
// | Ports    : clk_i, rst_i      - clock, sync active-high reset           |
// |            wr_en_i/wr_data_i - write request and word                  |
// |            rd_en_i           - pop head word (ignored when empty)      |
// |            rd_data_o         - head word, zero when empty              |
// |            full_o/empty_o    - occupancy flags                         |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module rans_word_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty when addresses match.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             w_full, w_empty, w_wr, w_rd;

  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign w_rd    = rd_en_i && !w_empty;
  // A pop in the same cycle frees the slot a write into a full FIFO needs.
  assign w_wr    = wr_en_i && (!w_full || w_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, w_wr};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, w_rd};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  assign rd_data_o = w_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign full_o    = w_full;
  assign empty_o   = w_empty;

endmodule
`default_nettype wire

// File: rtl/rans_byte_packer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : rans_byte_packer                                            |
// | Purpose  : Packs 0-2 rANS output bytes per cycle little-endian into    |
// |            32-bit words, buffers them and streams them out.            |
// | Ports    : clk_i, rst_i      - clock, sync active-high reset           |
// |            valid_i, enc_i    - byte count (0..2) and bytes             |
// |            flush_i           - close the current packet                |
// |            m_t*              - AXI4-Stream style master toward the DMA |
// |            flush_done_o      - flush fully written to the FIFO         |
// |            overflow_o, err_o - sticky word-dropped / protocol flags    |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module rans_byte_packer #(
  parameter int SYMBOL_WIDTH = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [1:0]                valid_i,
  input  logic [2*SYMBOL_WIDTH-1:0] enc_i,
  input  logic                      flush_i,
  output logic [31:0]               m_tdata_o,
  output logic [3:0]                m_tkeep_o,
  output logic                      m_tlast_o,
  output logic                      m_tvalid_o,
  input  logic                      m_tready_i,
  output logic                      flush_done_o,
  output logic                      overflow_o,
  output logic                      err_o
);

  import rans_pkg::*;

  pack_state_e state_q, state_d;
  logic [23:0] acc_q, acc_d;
  logic [1:0]  acc_cnt_q, acc_cnt_d;
  logic        flush_done_q, flush_done_d;
  logic        overflow_q, overflow_d;
  logic        err_q, err_d;

  logic [1:0]  w_vcnt;
  logic [15:0] w_in_bytes;
  logic [2:0]  w_n_total;
  logic [39:0] w_merged;
  logic        w_wr_en;
  logic [36:0] w_wr_word;
  logic [36:0] w_rd_word;
  logic        w_fifo_full, w_fifo_empty, w_rd_en;

  // Illegal count 3 is handled as 2 bytes.
  assign w_vcnt     = (valid_i == VLD_ILLEGAL) ? VLD_TWO : valid_i;
  assign w_in_bytes = (w_vcnt == VLD_NONE) ? 16'h0000 :
                      (w_vcnt == VLD_ONE)  ? {8'h00, enc_i[7:0]} : enc_i[15:0];
  assign w_n_total  = {1'b0, acc_cnt_q} + {1'b0, w_vcnt};
  // acc_q is kept zero above its valid bytes, so OR-ing in the shifted
  // input appends the new bytes right after the held ones.
  assign w_merged   = {16'h0000, acc_q} |
                      ({24'h000000, w_in_bytes} << {acc_cnt_q, 3'b000});

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    acc_cnt_d    = acc_cnt_q;
    flush_done_d = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_word    = '0;

    case (state_q)
      IDLE: begin
        if (flush_i) begin
          if (w_n_total == 3'd0) begin
            flush_done_d = 1'b1;
          end else if (w_n_total <= 3'd4) begin
            w_wr_en      = 1'b1;
            w_wr_word    = {1'b1, keep_mask(w_n_total), w_merged[31:0]};
            acc_d        = '0;
            acc_cnt_d    = 2'd0;
            flush_done_d = 1'b1;
          end else begin
            // Five bytes: full word now, the single leftover byte next cycle.
            w_wr_en   = 1'b1;
            w_wr_word = {1'b0, 4'b1111, w_merged[31:0]};
            acc_d     = {16'h0000, w_merged[39:32]};
            acc_cnt_d = 2'd1;
            state_d   = TAIL;
          end
        end else if (w_n_total >= 3'd4) begin
          w_wr_en   = 1'b1;
          w_wr_word = {1'b0, 4'b1111, w_merged[31:0]};
          acc_d     = {16'h0000, w_merged[39:32]};
          acc_cnt_d = w_n_total[1:0];
        end else begin
          acc_d     = w_merged[23:0];
          acc_cnt_d = w_n_total[1:0];
        end
      end
      TAIL: begin
        // Emit the tail byte; bytes arriving now open the next packet.
        w_wr_en      = 1'b1;
        w_wr_word    = {1'b1, 4'b0001, 24'h000000, acc_q[7:0]};
        acc_d        = {8'h00, w_in_bytes};
        acc_cnt_d    = w_vcnt;
        state_d      = IDLE;
        flush_done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    err_d      = err_q | (valid_i == VLD_ILLEGAL) | ((state_q == TAIL) && flush_i);
    overflow_d = overflow_q | (w_wr_en && w_fifo_full && !w_rd_en);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      acc_cnt_q    <= 2'd0;
      flush_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      flush_done_q <= flush_done_d;
      overflow_q   <= overflow_d;
      err_q        <= err_d;
    end
  end

  assign w_rd_en = !w_fifo_empty && m_tready_i;

  rans_word_fifo #(
    .WIDTH (37),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (w_wr_en),
    .wr_data_i (w_wr_word),
    .rd_en_i   (w_rd_en),
    .rd_data_o (w_rd_word),
    .full_o    (w_fifo_full),
    .empty_o   (w_fifo_empty)
  );

  assign m_tdata_o    = w_rd_word[31:0];
  assign m_tkeep_o    = w_rd_word[35:32];
  assign m_tlast_o    = w_rd_word[36];
  assign m_tvalid_o   = !w_fifo_empty;
  assign flush_done_o = flush_done_q;
  assign overflow_o   = overflow_q;
  assign err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rans_byte_packer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_rans_byte_packer                                         |
// | Purpose  : Directed and random stimulus for rans_byte_packer, checked  |
// |            against a byte-queue reference model.                       |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_rans_byte_packer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  valid_i;
  logic [15:0] enc_i;
  logic        flush_i;
  logic [31:0] m_tdata_o;
  logic [3:0]  m_tkeep_o;
  logic        m_tlast_o;
  logic        m_tvalid_o;
  logic        m_tready_i;
  logic        flush_done_o;
  logic        overflow_o;
  logic        err_o;

  rans_byte_packer #(
    .SYMBOL_WIDTH (8),
    .FIFO_DEPTH   (16)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .enc_i        (enc_i),
    .flush_i      (flush_i),
    .m_tdata_o    (m_tdata_o),
    .m_tkeep_o    (m_tkeep_o),
    .m_tlast_o    (m_tlast_o),
    .m_tvalid_o   (m_tvalid_o),
    .m_tready_i   (m_tready_i),
    .flush_done_o (flush_done_o),
    .overflow_o   (overflow_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: pending bytes of the open packet, expected words
  // ({last, keep, data}) in output order, and expected flag values.
  logic [7:0]  pend[$];
  logic [36:0] exp_q[$];
  logic        m_tail = 1'b0;
  logic        m_err  = 1'b0;
  logic        fd_exp = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic emit(input int k, input logic last);
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < k; i++) d[8*i +: 8] = pend.pop_front();
    exp_q.push_back({last, 4'((1 << k) - 1), d});
  endtask

  task automatic model_cycle(input logic [1:0] v, input logic [15:0] e, input logic fl);
    int nb;
    logic fd_next;
    nb = (v == 2'd3) ? 2 : int'(v);
    if (v == 2'd3) m_err = 1'b1;
    fd_next = 1'b0;
    if (nb >= 1) pend.push_back(e[7:0]);
    if (nb == 2) pend.push_back(e[15:8]);
    if (m_tail) begin
      // Cycle after a five-byte flush: tail already queued, flush ignored.
      m_tail  = 1'b0;
      fd_next = 1'b1;
      if (fl) m_err = 1'b1;
    end else if (fl) begin
      if (pend.size() == 5) begin
        emit(4, 1'b0);
        emit(1, 1'b1);
        m_tail = 1'b1;
      end else begin
        if (pend.size() > 0) emit(pend.size(), 1'b1);
        fd_next = 1'b1;
      end
    end else if (pend.size() >= 4) begin
      emit(4, 1'b0);
    end
    fd_exp = fd_next;
  endtask

  // One clock cycle: drive inputs, check outputs, advance the model.
  task automatic cyc(input logic [1:0] v, input logic [15:0] e, input logic fl, input logic rdy);
    logic [36:0] w;
    valid_i    = v;
    enc_i      = e;
    flush_i    = fl;
    m_tready_i = rdy;
    #1;
    check("flush_done", {63'd0, flush_done_o}, {63'd0, fd_exp});
    check("err", {63'd0, err_o}, {63'd0, m_err});
    if (m_tvalid_o && m_tready_i) begin
      check("word_expected", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("word", {27'd0, m_tlast_o, m_tkeep_o, m_tdata_o}, {27'd0, w});
      end
    end
    model_cycle(v, e, fl);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i      = 1'b1;
    valid_i    = 2'd0;
    enc_i      = 16'h0000;
    flush_i    = 1'b0;
    m_tready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    pend.delete();
    exp_q.delete();
    m_tail = 1'b0;
    m_err  = 1'b0;
    fd_exp = 1'b0;
  endtask

  function automatic logic [63:0] out_word();
    return {27'd0, m_tlast_o, m_tkeep_o, m_tdata_o};
  endfunction

  initial begin
    logic [1:0]  rv;
    logic [15:0] re;
    logic        rf, rr;

    do_reset();
    check("rst_tvalid", {63'd0, m_tvalid_o}, 64'd0);
    check("rst_word", out_word(), 64'd0);
    check("rst_flags", {61'd0, flush_done_o, overflow_o, err_o}, 64'd0);

    // Alignment and one-cycle latency.
    cyc(2'd2, 16'h0201, 1'b0, 1'b1);
    check("align_no_word_yet", {63'd0, m_tvalid_o}, 64'd0);
    cyc(2'd2, 16'h0403, 1'b0, 1'b1);
    check("align_w0_latency", {63'd0, m_tvalid_o}, 64'd1);
    check("align_w0", out_word(), {27'd0, 1'b0, 4'hF, 32'h04030201});
    cyc(2'd2, 16'h0605, 1'b0, 1'b1);
    cyc(2'd2, 16'h0807, 1'b0, 1'b1);
    check("align_w1", out_word(), {27'd0, 1'b0, 4'hF, 32'h08070605});

    // Odd byte counts.
    cyc(2'd1, 16'h00AA, 1'b0, 1'b1);
    cyc(2'd2, 16'hCCBB, 1'b0, 1'b1);
    cyc(2'd1, 16'h00DD, 1'b0, 1'b1);
    check("odd_word", out_word(), {27'd0, 1'b0, 4'hF, 32'hDDCCBBAA});

    // Partial flush of three held bytes.
    cyc(2'd2, 16'h2211, 1'b0, 1'b1);
    cyc(2'd1, 16'h0033, 1'b0, 1'b1);
    cyc(2'd0, 16'h0000, 1'b1, 1'b1);
    check("pflush_word", out_word(), {27'd0, 1'b1, 4'h7, 32'h00332211});
    check("pflush_done", {63'd0, flush_done_o}, 64'd1);

    // Flush with five bytes, then bytes in the tail cycle start a new packet.
    cyc(2'd2, 16'h2211, 1'b0, 1'b1);
    cyc(2'd1, 16'h0033, 1'b0, 1'b1);
    cyc(2'd2, 16'h5544, 1'b1, 1'b1);
    check("f5_full", out_word(), {27'd0, 1'b0, 4'hF, 32'h44332211});
    check("f5_no_done_yet", {63'd0, flush_done_o}, 64'd0);
    cyc(2'd2, 16'h7766, 1'b0, 1'b1);
    check("f5_tail", out_word(), {27'd0, 1'b1, 4'h1, 32'h00000055});
    cyc(2'd2, 16'h9988, 1'b0, 1'b1);
    check("f5_next_packet", out_word(), {27'd0, 1'b0, 4'hF, 32'h99887766});

    // Illegal count, then reset with two bytes held.
    cyc(2'd3, 16'hA2A1, 1'b0, 1'b1);
    check("err_set", {63'd0, err_o}, 64'd1);
    do_reset();
    check("rst2_flags", {61'd0, flush_done_o, overflow_o, err_o}, 64'd0);
    check("rst2_tvalid", {63'd0, m_tvalid_o}, 64'd0);
    cyc(2'd2, 16'h3231, 1'b0, 1'b1);
    cyc(2'd2, 16'h3433, 1'b0, 1'b1);
    check("rst2_clean_word", out_word(), {27'd0, 1'b0, 4'hF, 32'h34333231});
    cyc(2'd0, 16'h0000, 1'b0, 1'b1);

    // Overflow: 17 words with the sink stalled; the 17th is dropped.
    for (int i = 0; i < 34; i++) begin
      cyc(2'd2, {8'(2*i + 1), 8'(2*i)}, 1'b0, 1'b0);
    end
    void'(exp_q.pop_back());
    check("ovf_set", {63'd0, overflow_o}, 64'd1);
    check("ovf_head", out_word(), {27'd0, 1'b0, 4'hF, 32'h03020100});
    for (int i = 0; i < 20; i++) cyc(2'd0, 16'h0000, 1'b0, 1'b1);
    check("ovf_drained", {32'd0, 32'(exp_q.size())}, 64'd0);
    check("ovf_tvalid_low", {63'd0, m_tvalid_o}, 64'd0);
    check("ovf_sticky", {63'd0, overflow_o}, 64'd1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      rv = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 49) == 0) rv = 2'd3;
      re = 16'($urandom);
      rf = ($urandom_range(0, 9) == 0);
      rr = ($urandom_range(0, 4) != 0);
      cyc(rv, re, rf, rr);
    end
    cyc(2'd0, 16'h0000, 1'b1, 1'b1);
    for (int i = 0; i < 24; i++) cyc(2'd0, 16'h0000, 1'b0, 1'b1);
    check("rand_drained", {32'd0, 32'(exp_q.size())}, 64'd0);
    check("rand_no_overflow", {63'd0, overflow_o}, 64'd0);
    check("rand_tvalid_low", {63'd0, m_tvalid_o}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rans_byte_packer.md
# rans_byte_packer

Downstream of the multi-stream rANS encoder. Takes the per-cycle renormalisation output (0–2 bytes per cycle, already interleaved across streams in round-robin slot order) and packs it little-endian into 32-bit words. Words are buffered in a small FIFO and presented on an AXI4-Stream-style master port toward the DMA. The encoder side has no backpressure, so buffer overflow is detected and flagged, never stalled.

## Interface
Parameters:
- `SYMBOL_WIDTH`, 8: byte width. Only 8 is supported; the input word is `2*SYMBOL_WIDTH` bits.
- `FIFO_DEPTH`, 16: output word FIFO depth. Must be a power of 2, at least 4.

Ports:
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `valid_i`, in, 2: byte count this cycle. 0 = none, 1 = `enc_i[7:0]`, 2 = `enc_i[7:0]` then `enc_i[15:8]`. 3 is illegal: treated as 2 and sets `err_o`.
- `enc_i`, in, 16: encoded bytes.
- `flush_i`, in, 1: single-cycle pulse that closes the current packet.
- `m_tdata_o`, out, 32: output word; the first byte is in [7:0].
- `m_tkeep_o`, out, 4: byte enables, always contiguous from bit 0.
- `m_tlast_o`, out, 1: last word of a packet.
- `m_tvalid_o`, out, 1: word available.
- `m_tready_i`, in, 1: sink accepts.
- `flush_done_o`, out, 1: one-cycle pulse when a flush has fully entered the FIFO.
- `overflow_o`, out, 1: sticky; a word was dropped because the FIFO was full.
- `err_o`, out, 1: sticky; `valid_i == 3` was seen.

## Operation
- **Accumulator:** 24-bit byte buffer `acc_r` plus `acc_cnt_r` (0–3). Each cycle the incoming bytes are appended after the held bytes, giving a total `n = acc_cnt_r + valid_i` in the range 0–5.
  - n ≥ 4: write the lowest 4 bytes to the FIFO with keep 1111 and last 0; the remaining n−4 bytes stay in the accumulator.
  - n < 4: hold all bytes.
- **Flush, n = 0:** no word written. `flush_done_o` pulses the next cycle.
- **Flush, 1 ≤ n ≤ 4:** one word is written with keep `(1<<n)−1` and tlast 1. The accumulator clears. `flush_done_o` pulses the next cycle.
- **Flush, n = 5:** a full word (last 0) is written this cycle, and state `TAIL` is entered. In `TAIL`:
  - The 1-byte tail word (keep 0001, last 1) is written.
  - Bytes arriving in the `TAIL` cycle start a new packet in the cleared accumulator.
  - `flush_done_o` pulses the cycle after `TAIL`.
- **State machine:** `IDLE` → `TAIL` on flush with n = 5; `TAIL` → `IDLE` unconditionally. `flush_i` asserted while in `TAIL` is ignored and sets `err_o`.
- **Write rate:** at most one FIFO write per cycle in every case.
- **FIFO full on a write:** the word is dropped and `overflow_o` is set. Accumulator bookkeeping proceeds as if the write had succeeded, so byte alignment is kept.
- **Output handshake:** a word transfers when `m_tvalid_o && m_tready_i`. `m_tdata_o`, `m_tkeep_o` and `m_tlast_o` are stable while valid and not ready.
- **Simultaneous FIFO write and read when full:** the write is accepted, because the read frees a slot in the same cycle.

## Timing
- **Reset values:** all outputs are 0. `acc_cnt_r = 0`, state `IDLE`, FIFO empty. Sticky flags clear only on `rst_i`.
- **Latency:** the word completed in cycle t is on `m_tvalid_o` in cycle t+1 (registered FIFO write, first-word-fall-through read).
- **Throughput:** input peak is 2 bytes/cycle, so at most one word every 2 cycles. Output can sustain one word per cycle.
- **Reset mid-packet:** held bytes and FIFO contents are discarded. No tlast is generated.

## Structure
- **`rans_pkg`:** `WORD_BYTES = 4`; the `valid_i` encodings `VLD_NONE`, `VLD_ONE`, `VLD_TWO`; and `typedef enum {IDLE, TAIL}` for the packer state.
- **Sub-module `rans_word_fifo`:** synchronous first-word-fall-through FIFO. Width 37 (data + keep + last), depth `FIFO_DEPTH`. It provides `full`/`empty` and uses pointers one bit wider than the address for the wrap test.
- **`rans_byte_packer` proper:** accumulator, flush FSM and flags.

## Test plan
- **Alignment:** `valid_i = 2` for 4 cycles with bytes 01..08 → words 0x04030201 and 0x08070605, keep 1111, last 0, each visible one cycle after completion.
- **Odd counts:** `valid_i` sequence 1,2,1 (bytes AA, BB CC, DD) → a single word 0xDDCCBBAA, keep 1111.
- **Partial flush:** 3 bytes 11 22 33 held, then `flush_i` with `valid_i = 0` → word 0x00332211, keep 0111, last 1; `flush_done_o` pulses the next cycle.
- **Flush n = 5:** 3 held bytes + `flush_i` with `valid_i = 2` (44 55) → 0x44332211 (last 0), then 0x00000055 keep 0001 last 1. Bytes arriving in the `TAIL` cycle appear in the next packet.
- **Overflow:** `m_tready_i = 0`, `FIFO_DEPTH = 16`, then 17 words of input → 16 words held and `overflow_o = 1`. Release ready → 16 words drain in order and `m_tvalid_o` drops.
- **Reset mid-packet and illegal count:** `valid_i = 3` sets `err_o`; `rst_i` with 2 bytes held clears everything, and the next 4 bytes form a clean word.
